// File: rtl/sort_pkg.sv
// Shared sizes, state encoding and entry type for the intensity sort readout.
// Optional build macro used by this block: SORT_SKIP_ZERO_EN.
package sort_pkg;

  localparam int N    = 3;
  localparam int IW   = 5;
  localparam int DW   = 10;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  typedef struct packed {
    logic [IW-1:0] inten;
    logic [DW-1:0] data;
  } entry_t;

  // Number of entries still waiting to be output.
  function automatic logic [CNTW-1:0] count_unused(input logic [N-1:0] used);
    logic [CNTW-1:0] c;
    c = {CNTW{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (!used[k]) begin
        c = c + CNTW'(1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sort_readout_if.sv
// Snapshot-in / sorted-entry-out bus of the sort readout block.
interface sort_readout_if;
  import sort_pkg::*;

  logic            snap_vld;
  logic            snap_rdy;
  logic [N*IW-1:0] snap_int;
  logic [N*DW-1:0] snap_data;
  logic            out_vld;
  logic            out_rdy;
  logic [IW-1:0]   out_int;
  logic [DW-1:0]   out_data;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            done;

  // Capture-stage / packer side.
  modport master (
    output snap_vld, snap_int, snap_data, out_rdy,
    input  snap_rdy, out_vld, out_int, out_data, out_idx, out_last, done
  );

  // Readout block side.
  modport slave (
    input  snap_vld, snap_int, snap_data, out_rdy,
    output snap_rdy, out_vld, out_int, out_data, out_idx, out_last, done
  );

endinterface

// File: rtl/sort_max_scan.sv
// Running maximum tracker: looks at one entry per cycle and keeps the best
// (highest intensity, lowest index on ties) seen in the current pass.
// The outputs already include the entry under the cursor this cycle.
module sort_max_scan
  import sort_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_first,
  input  logic            i_used,
  input  logic [IDXW-1:0] i_idx,
  input  logic [IW-1:0]   i_int,
  output logic [IDXW-1:0] o_best_idx,
  output logic [IW-1:0]   o_best_int
);

  logic            r_have;
  logic [IDXW-1:0] r_idx;
  logic [IW-1:0]   r_int;
  logic            w_have_eff;
  logic            w_take;

  // Merge the current candidate with the best held from earlier cycles; strict > keeps the lower index on ties.
  always_comb begin
    w_have_eff = r_have && !i_first;
    w_take     = !i_used && (!w_have_eff || (i_int > r_int));
    if (w_take) begin
      o_best_idx = i_idx;
      o_best_int = i_int;
    end else begin
      o_best_idx = r_idx;
      o_best_int = r_int;
    end
  end

  // Hold the running best across the cycles of one scan pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have <= 1'b0;
      r_idx  <= {IDXW{1'b0}};
      r_int  <= {IW{1'b0}};
    end else if (i_en) begin
      r_have <= w_have_eff || w_take;
      r_idx  <= o_best_idx;
      r_int  <= o_best_int;
    end else begin
      r_have <= r_have;
      r_idx  <= r_idx;
      r_int  <= r_int;
    end
  end

endmodule

// File: rtl/sort_readout.sv
// Drain side of the intensity sort buffer: captures an N-entry snapshot and
// streams the entries out in descending intensity order, one scan pass
// (one cycle per entry) per output.
// Optional build macro: SORT_SKIP_ZERO_EN -- zero-intensity entries are
// dropped at capture; an all-zero snapshot just produces a done pulse.
module sort_readout
  import sort_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  sort_readout_if.slave bus
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t          r_state, w_state_nxt;
  entry_t          r_snap [N];
  entry_t          w_snap_nxt [N];
  logic [N-1:0]    r_used, w_used_nxt;
  logic [IDXW-1:0] r_cnt, w_cnt_nxt;
  logic            r_out_vld, w_out_vld_nxt;
  logic [IW-1:0]   r_out_int, w_out_int_nxt;
  logic [DW-1:0]   r_out_data, w_out_data_nxt;
  logic [IDXW-1:0] r_out_idx, w_out_idx_nxt;
  logic            r_out_last, w_out_last_nxt;
  logic            r_done, w_done_nxt;

  logic            w_scan_en;
  logic            w_scan_first;
  logic [IDXW-1:0] w_best_idx;
  logic [IW-1:0]   w_best_int;
  logic [N-1:0]    w_init_used;

  sort_max_scan u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_scan_en),
    .i_first    (w_scan_first),
    .i_used     (r_used[r_cnt]),
    .i_idx      (r_cnt),
    .i_int      (r_snap[r_cnt].inten),
    .o_best_idx (w_best_idx),
    .o_best_int (w_best_int)
  );

  // Used mask loaded at capture: empty, or the zero-intensity entries when those are skipped.
  always_comb begin
    w_init_used = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
`ifdef SORT_SKIP_ZERO_EN
      w_init_used[k] = (bus.snap_int[k*IW +: IW] == {IW{1'b0}});
`else
      w_init_used[k] = 1'b0;
`endif
    end
  end

  // Next-state, snapshot, used-mask and output-register logic of the readout FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_snap_nxt     = r_snap;
    w_used_nxt     = r_used;
    w_cnt_nxt      = r_cnt;
    w_out_vld_nxt  = r_out_vld;
    w_out_int_nxt  = r_out_int;
    w_out_data_nxt = r_out_data;
    w_out_idx_nxt  = r_out_idx;
    w_out_last_nxt = r_out_last;
    w_done_nxt     = 1'b0;
    w_scan_en      = 1'b0;
    w_scan_first   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.snap_vld) begin
          for (int k = 0; k < N; k++) begin
            w_snap_nxt[k].inten = bus.snap_int[k*IW +: IW];
            w_snap_nxt[k].data  = bus.snap_data[k*DW +: DW];
          end
          w_used_nxt = w_init_used;
          w_cnt_nxt  = {IDXW{1'b0}};
          if (&w_init_used) begin
            // Nothing to output: finish straight away.
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SCAN;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        w_scan_en    = 1'b1;
        w_scan_first = (r_cnt == {IDXW{1'b0}});
        if (r_cnt == LAST_IDX) begin
          w_out_vld_nxt  = 1'b1;
          w_out_int_nxt  = w_best_int;
          w_out_data_nxt = r_snap[w_best_idx].data;
          w_out_idx_nxt  = w_best_idx;
          w_out_last_nxt = (count_unused(r_used) == CNTW'(1));
          w_cnt_nxt      = {IDXW{1'b0}};
          w_state_nxt    = PRESENT;
        end else begin
          w_cnt_nxt = r_cnt + IDXW'(1);
        end
      end
      PRESENT: begin
        if (bus.out_rdy) begin
          w_used_nxt[r_out_idx] = 1'b1;
          w_out_vld_nxt         = 1'b0;
          if (r_out_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = {IDXW{1'b0}};
            w_state_nxt = SCAN;
          end
        end else begin
          w_state_nxt = PRESENT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, snapshot and output registers; reset discards any partially drained snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      for (int k = 0; k < N; k++) begin
        r_snap[k].inten <= {IW{1'b0}};
        r_snap[k].data  <= {DW{1'b0}};
      end
      r_used     <= {N{1'b0}};
      r_cnt      <= {IDXW{1'b0}};
      r_out_vld  <= 1'b0;
      r_out_int  <= {IW{1'b0}};
      r_out_data <= {DW{1'b0}};
      r_out_idx  <= {IDXW{1'b0}};
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_snap     <= w_snap_nxt;
      r_used     <= w_used_nxt;
      r_cnt      <= w_cnt_nxt;
      r_out_vld  <= w_out_vld_nxt;
      r_out_int  <= w_out_int_nxt;
      r_out_data <= w_out_data_nxt;
      r_out_idx  <= w_out_idx_nxt;
      r_out_last <= w_out_last_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.snap_rdy = (r_state == IDLE);
  assign bus.out_vld  = r_out_vld;
  assign bus.out_int  = r_out_int;
  assign bus.out_data = r_out_data;
  assign bus.out_idx  = r_out_idx;
  assign bus.out_last = r_out_last;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_sort_readout.sv
// Self-checking bench for sort_readout: directed table, hand-written reset
// and skip-zero sequences, then randomized snapshots against a rank model.
module tb_sort_readout;
  import sort_pkg::*;

`ifdef SORT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sort_readout_if bus();

  sort_readout dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N*IW-1:0]     ints;
    logic [N*DW-1:0]     dat;
    logic [N-1:0][7:0]   order;
    int                  cnt;
    int                  stall;
    bit                  poke;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entry k takes part in the output stream?
  function automatic bit emits(input logic [IW-1:0] v);
    return (v != '0) || !SKIP;
  endfunction

  // Reference: output position of entry k = number of emitted entries ranked ahead of it.
  task automatic model(input logic [N*IW-1:0] ints, output int order[N], output int cnt);
    logic [IW-1:0] vk, vj;
    int rank;
    cnt = 0;
    for (int k = 0; k < N; k++) order[k] = 0;
    for (int k = 0; k < N; k++) begin
      vk = ints[k*IW +: IW];
      if (emits(vk)) begin
        rank = 0;
        for (int j = 0; j < N; j++) begin
          vj = ints[j*IW +: IW];
          if (emits(vj) && ((vj > vk) || (vj == vk && j < k))) rank++;
        end
        order[rank] = k;
        cnt++;
      end
    end
  endtask

  // Offer a snapshot, drain it and check every output, latency, hold and done.
  task automatic drain(input logic [N*IW-1:0] ints, input logic [N*DW-1:0] dat,
                       input int order[N], input int cnt, input int stall, input bit poke);
    int k;
    k = 0;
    while (bus.snap_rdy !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("snap_rdy_idle", bus.snap_rdy, 1);
    bus.snap_vld  = 1'b1;
    bus.snap_int  = ints;
    bus.snap_data = dat;
    bus.out_rdy   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.snap_vld = 1'b0;
    if (cnt == 0) begin
      check("zero_done", bus.done, 1);
      check("zero_no_vld", bus.out_vld, 0);
      check("zero_snap_rdy", bus.snap_rdy, 1);
      @(negedge clk);
      check("zero_done_pulse", bus.done, 0);
      check("zero_no_vld2", bus.out_vld, 0);
      return;
    end
    for (int p = 0; p < cnt; p++) begin
      k = 0;
      while (bus.out_vld !== 1'b1 && k < 4*N) begin
        if (poke && p == 0 && k == 0) begin
          bus.snap_vld  = 1'b1;
          bus.snap_int  = {N{ {IW{1'b1}} }};
          bus.snap_data = {N{ {DW{1'b1}} }};
          check("busy_snap_rdy", bus.snap_rdy, 0);
        end else begin
          bus.snap_vld = 1'b0;
        end
        bus.out_rdy = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        k++;
      end
      bus.snap_vld = 1'b0;
      check("vld_latency", k, N);
      for (int s = 0; s <= stall; s++) begin
        check("out_vld", bus.out_vld, 1);
        check("out_idx", bus.out_idx, order[p]);
        check("out_int", bus.out_int, ints[order[p]*IW +: IW]);
        check("out_data", bus.out_data, dat[order[p]*DW +: DW]);
        check("out_last", bus.out_last, (p == cnt - 1) ? 1 : 0);
        check("done_low", bus.done, 0);
        bus.out_rdy = (s == stall);
        @(posedge clk);
        @(negedge clk);
      end
      check("vld_drop", bus.out_vld, 0);
    end
    bus.out_rdy = 1'b0;
    check("done_pulse", bus.done, 1);
    check("snap_rdy_with_done", bus.snap_rdy, 1);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int order[N];
    for (int i = 0; i < N; i++) order[i] = int'(v.order[i]);
    drain(v.ints, v.dat, order, v.cnt, v.stall, v.poke);
  endtask

  initial begin
    int order[N];
    int cnt;
    int k;
    logic [N*IW-1:0] ri;
    logic [N*DW-1:0] rd;

    // Directed table; order[i] is the index expected at output position i.
    vecs[0] = '{ints: {5'd3, 5'd20, 5'd7}, dat: {10'h033, 10'h022, 10'h011},
                order: {8'd2, 8'd0, 8'd1}, cnt: 3, stall: 0, poke: 1'b0};
    vecs[1] = '{ints: {5'd5, 5'd5, 5'd5}, dat: {10'h3C3, 10'h2B2, 10'h1A1},
                order: {8'd2, 8'd1, 8'd0}, cnt: 3, stall: 0, poke: 1'b0};
    vecs[2] = '{ints: {5'd30, 5'd4, 5'd12}, dat: {10'h155, 10'h2AA, 10'h0F0},
                order: {8'd1, 8'd0, 8'd2}, cnt: 3, stall: 10, poke: 1'b0};
    vecs[3] = '{ints: {5'd17, 5'd1, 5'd9}, dat: {10'h001, 10'h002, 10'h003},
                order: {8'd1, 8'd0, 8'd2}, cnt: 3, stall: 1, poke: 1'b1};
`ifdef SORT_SKIP_ZERO_EN
    vecs[4] = '{ints: {5'd0, 5'd9, 5'd0}, dat: {10'h300, 10'h200, 10'h100},
                order: {8'd0, 8'd0, 8'd1}, cnt: 1, stall: 0, poke: 1'b0};
    vecs[5] = '{ints: {5'd31, 5'd0, 5'd31}, dat: {10'h3FF, 10'h000, 10'h111},
                order: {8'd0, 8'd2, 8'd0}, cnt: 2, stall: 2, poke: 1'b0};
`else
    vecs[4] = '{ints: {5'd0, 5'd9, 5'd0}, dat: {10'h300, 10'h200, 10'h100},
                order: {8'd2, 8'd0, 8'd1}, cnt: 3, stall: 0, poke: 1'b0};
    vecs[5] = '{ints: {5'd31, 5'd0, 5'd31}, dat: {10'h3FF, 10'h000, 10'h111},
                order: {8'd1, 8'd2, 8'd0}, cnt: 3, stall: 2, poke: 1'b0};
`endif

    bus.snap_vld  = 1'b0;
    bus.snap_int  = '0;
    bus.snap_data = '0;
    bus.out_rdy   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_out_int", bus.out_int, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_done", bus.done, 0);
    check("rst_snap_rdy", bus.snap_rdy, 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while an entry is being presented under backpressure.
    bus.snap_vld  = 1'b1;
    bus.snap_int  = vecs[2].ints;
    bus.snap_data = vecs[2].dat;
    @(posedge clk);
    @(negedge clk);
    bus.snap_vld = 1'b0;
    k = 0;
    while (bus.out_vld !== 1'b1 && k < 4*N) begin
      @(negedge clk);
      k++;
    end
    check("rstmid_vld_seen", bus.out_vld, 1);
    check("rstmid_snap_rdy_busy", bus.snap_rdy, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out_vld", bus.out_vld, 0);
    check("rstmid_out_int", bus.out_int, 0);
    check("rstmid_out_data", bus.out_data, 0);
    check("rstmid_out_idx", bus.out_idx, 0);
    check("rstmid_snap_rdy", bus.snap_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_snap_rdy_after", bus.snap_rdy, 1);
    run_vec(vecs[0]);

    // All-zero snapshot: done right after accept when zeros are skipped, else three zero outputs.
    model('0, order, cnt);
    check("model_zero_cnt", cnt, SKIP ? 0 : N);
    drain('0, {10'h0C3, 10'h0B2, 10'h0A1}, order, cnt, 0, 1'b0);

    // Randomized snapshots; small intensity ranges force ties and zeros.
    for (int t = 0; t < 30; t++) begin
      for (int e = 0; e < N; e++) begin
        ri[e*IW +: IW] = (t % 2 == 0) ? IW'($urandom_range(0, 2)) : IW'($urandom_range(0, 31));
        rd[e*DW +: DW] = DW'($urandom);
      end
      model(ri, order, cnt);
      drain(ri, rd, order, cnt, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
